// File: rtl/mux41_rr_arb_pkg.sv
// Shared types for the 4-source round-robin arbiter / registered 4:1 selector.
package mux41_rr_arb_pkg;

  localparam int NSRC = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  typedef logic [1:0] sel_t;

  // One-hot grant vector for an encoded source index.
  function automatic logic [NSRC-1:0] onehot(input sel_t s);
    logic [NSRC-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux41_rr_arb_if.sv
// Request/data/grant bundle between the four sources and the arbiter.
// slave: arbiter side, master: source/consumer side.
interface mux41_rr_arb_if
  import mux41_rr_arb_pkg::*;
#(
  parameter int DW = 8
);
  logic            iEN;
  logic [NSRC-1:0] iREQ;
  logic [DW-1:0]   iA;
  logic [DW-1:0]   iB;
  logic [DW-1:0]   iC;
  logic [DW-1:0]   iD;
  logic [NSRC-1:0] oGNT;
  sel_t            oSEL;
  logic [DW-1:0]   oOUT;
  logic            oVALID;
  logic            oBUSY;
  logic            oPREEMPT;

  modport slave (
    input  iEN, iREQ, iA, iB, iC, iD,
    output oGNT, oSEL, oOUT, oVALID, oBUSY, oPREEMPT
  );

  modport master (
    output iEN, iREQ, iA, iB, iC, iD,
    input  oGNT, oSEL, oOUT, oVALID, oBUSY, oPREEMPT
  );
endinterface

// File: rtl/mux41_rr_arb_pick.sv
// Combinational round-robin picker: first request at or after the pointer,
// wrapping 3->0, with an exclude mask to skip the current owner.
module mux41_rr_arb_pick
  import mux41_rr_arb_pkg::*;
(
  input  logic [NSRC-1:0] i_req,
  input  sel_t            i_ptr,
  input  logic [NSRC-1:0] i_excl,
  output sel_t            o_win,
  output logic            o_any
);

  logic [NSRC-1:0] w_cand;
  logic            w_found;
  sel_t            w_idx;

  // Scan candidates starting at the pointer; 2-bit index wraps naturally.
  always_comb begin
    w_cand  = i_req & ~i_excl;
    w_found = 1'b0;
    w_idx   = '0;
    o_win   = i_ptr;
    for (int i = 0; i < NSRC; i++) begin
      w_idx = i_ptr + sel_t'(i);
      if (!w_found && w_cand[w_idx]) begin
        o_win   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign o_any = |w_cand;

endmodule

// File: rtl/mux41_rr_arb.sv
// Round-robin arbiter with registered 4:1 data selector.
// Optional hold limit / forced rotation enabled by defining MUX41_ARB_TIMEOUT_EN.
//
// state    | meaning
// ST_IDLE  | no owner, oGNT=0; waits for iEN=1 and any request
// ST_GRANT | owner oSEL holds the path; kept while its request stays high
module mux41_rr_arb
  import mux41_rr_arb_pkg::*;
#(
  parameter int DW       = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic           iCLK,
  input  logic           iRSTn,
  mux41_rr_arb_if.slave  bus
);

  if (MAX_HOLD < 1) begin : g_hold_chk
    $error("MAX_HOLD must be >= 1");
  end

  state_t          r_state, w_state_nxt;
  sel_t            r_sel, w_sel_nxt;
  sel_t            r_ptr, w_ptr_nxt;
  logic [NSRC-1:0] r_gnt;
  logic [DW-1:0]   r_out;
  logic            r_valid;
  logic [DW-1:0]   w_src;
  logic [NSRC-1:0] w_excl;
  sel_t            w_win;
  logic            w_any;

`ifdef MUX41_ARB_TIMEOUT_EN
  localparam int              HW        = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]   HOLD_MAX  = HW'(MAX_HOLD);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_HOLD - 1);
  logic [HW-1:0] r_hold, w_hold_nxt;
  logic          r_preempt, w_preempt_nxt;
`endif

  // The owner is never a handoff/rotation candidate; in idle nobody is excluded.
  assign w_excl = (r_state == ST_GRANT) ? onehot(r_sel) : '0;

  mux41_rr_arb_pick u_pick (
    .i_req  (bus.iREQ),
    .i_ptr  (r_ptr),
    .i_excl (w_excl),
    .o_win  (w_win),
    .o_any  (w_any)
  );

  // Next-state, owner, pointer and hold-count decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
`ifdef MUX41_ARB_TIMEOUT_EN
    w_hold_nxt    = r_hold;
    w_preempt_nxt = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (bus.iEN && w_any) begin
          w_state_nxt = ST_GRANT;
          w_sel_nxt   = w_win;
          w_ptr_nxt   = w_win + 2'd1;
`ifdef MUX41_ARB_TIMEOUT_EN
          w_hold_nxt  = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (bus.iREQ[r_sel]) begin
`ifdef MUX41_ARB_TIMEOUT_EN
          // >= rather than == so an owner that saturated while alone is
          // still rotated once contention appears.
          if (r_hold >= HOLD_LAST && w_any && bus.iEN) begin
            w_sel_nxt     = w_win;
            w_ptr_nxt     = w_win + 2'd1;
            w_hold_nxt    = '0;
            w_preempt_nxt = 1'b1;
          end else if (r_hold != HOLD_MAX) begin
            w_hold_nxt = r_hold + 1'b1;
          end
`endif
        end else if (w_any && bus.iEN) begin
          w_sel_nxt   = w_win;
          w_ptr_nxt   = w_win + 2'd1;
`ifdef MUX41_ARB_TIMEOUT_EN
          w_hold_nxt  = '0;
`endif
        end else begin
          w_state_nxt = ST_IDLE;
`ifdef MUX41_ARB_TIMEOUT_EN
          w_hold_nxt  = '0;
`endif
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Source selection follows the registered owner code.
  always_comb begin
    case (r_sel)
      2'd0:    w_src = bus.iA;
      2'd1:    w_src = bus.iB;
      2'd2:    w_src = bus.iC;
      default: w_src = bus.iD;
    endcase
  end

  // FSM, pointer, grant and datapath registers.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= (w_state_nxt == ST_GRANT) ? onehot(w_sel_nxt) : '0;
      r_out   <= w_src;
      r_valid <= |r_gnt;
    end
  end

`ifdef MUX41_ARB_TIMEOUT_EN
  // Hold counter and preemption pulse.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_hold    <= '0;
      r_preempt <= 1'b0;
    end else begin
      r_hold    <= w_hold_nxt;
      r_preempt <= w_preempt_nxt;
    end
  end
  assign bus.oPREEMPT = r_preempt;
`else
  assign bus.oPREEMPT = 1'b0;
`endif

  assign bus.oGNT   = r_gnt;
  assign bus.oSEL   = r_sel;
  assign bus.oOUT   = r_out;
  assign bus.oVALID = r_valid;
  assign bus.oBUSY  = (r_state == ST_GRANT);

endmodule

// File: tb/tb_mux41_rr_arb.sv
// Bench for mux41_rr_arb: directed scenarios plus randomized traffic against
// a behavioural arbitration model. Honours MUX41_ARB_TIMEOUT_EN.
module tb_mux41_rr_arb;

  localparam int DW = 8;
  localparam int MH = 4;
`ifdef MUX41_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mux41_rr_arb_if #(.DW(DW)) bus ();

  mux41_rr_arb #(.DW(DW), .MAX_HOLD(MH)) dut (
    .iCLK  (clk),
    .iRSTn (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: owner index or -1 when idle.
  int            m_owner, m_sel, m_ptr, m_hold;
  logic [DW-1:0] m_out;
  bit            m_valid, m_preempt;

  function automatic int pick(input logic [3:0] req, input int ptr, input int excl);
    for (int i = 0; i < 4; i++) begin
      int j;
      j = (ptr + i) % 4;
      if (req[j] && j != excl) return j;
    end
    return -1;
  endfunction

  function automatic logic [3:0] gnt_of(input int o);
    logic [3:0] v;
    v = 4'b0000;
    if (o >= 0) v[o] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_sel = 0; m_ptr = 0; m_hold = 0;
    m_out = '0; m_valid = 1'b0; m_preempt = 1'b0;
  endtask

  task automatic model_step(input bit en, input logic [3:0] req);
    logic [DW-1:0] src [4];
    int w, k;
    src[0] = bus.iA; src[1] = bus.iB; src[2] = bus.iC; src[3] = bus.iD;
    m_out     = src[m_sel];
    m_valid   = (m_owner >= 0);
    m_preempt = 1'b0;
    if (m_owner < 0) begin
      if (en && req != 4'b0) begin
        w = pick(req, m_ptr, -1);
        m_owner = w; m_sel = w; m_ptr = (w + 1) % 4; m_hold = 0;
      end
    end else begin
      k = m_owner;
      w = pick(req, m_ptr, k);
      if (req[k]) begin
        if (TO_EN && m_hold >= MH - 1 && w >= 0 && en) begin
          m_owner = w; m_sel = w; m_ptr = (w + 1) % 4; m_hold = 0; m_preempt = 1'b1;
        end else if (m_hold < MH) begin
          m_hold++;
        end
      end else if (w >= 0 && en) begin
        m_owner = w; m_sel = w; m_ptr = (w + 1) % 4; m_hold = 0;
      end else begin
        m_owner = -1; m_hold = 0;
      end
    end
  endtask

  // Called at a falling edge; leaves the bench at the next falling edge.
  task automatic drive_step(input bit en, input logic [3:0] req);
    bus.iEN  = en;
    bus.iREQ = req;
    model_step(en, req);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    bus.iEN = 1'b1; bus.iREQ = 4'hF;
    bus.iA = 8'h11; bus.iB = 8'h22; bus.iC = 8'h33; bus.iD = 8'h44;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.oGNT !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt: got %b want 0000", bus.oGNT); end
    n_cmp++; if (bus.oSEL !== 2'd0) begin n_bad++; $display("FAIL reset_sel: got %0d want 0", bus.oSEL); end
    n_cmp++; if (bus.oOUT !== 8'h00) begin n_bad++; $display("FAIL reset_out: got %h want 00", bus.oOUT); end
    n_cmp++; if (bus.oVALID !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.oVALID); end
    n_cmp++; if (bus.oBUSY !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.oBUSY); end
    n_cmp++; if (bus.oPREEMPT !== 1'b0) begin n_bad++; $display("FAIL reset_preempt: got %b want 0", bus.oPREEMPT); end
    rst_n = 1'b1;
    model_reset();
    drive_step(1'b1, 4'hF);
    n_cmp++; if (bus.oGNT !== 4'b0001) begin n_bad++; $display("FAIL reset_first_gnt: got %b want 0001", bus.oGNT); end
    n_cmp++; if (bus.oSEL !== 2'd0) begin n_bad++; $display("FAIL reset_first_sel: got %0d want 0", bus.oSEL); end
    n_cmp++; if (bus.oVALID !== 1'b0) begin n_bad++; $display("FAIL reset_first_valid: got %b want 0", bus.oVALID); end
  endtask

  task automatic test_handoff();
    apply_reset();
    drive_step(1'b1, 4'b1010);
    n_cmp++; if (bus.oGNT !== 4'b0010) begin n_bad++; $display("FAIL handoff_b: got %b want 0010", bus.oGNT); end
    drive_step(1'b1, 4'b1000);
    n_cmp++; if (bus.oGNT !== 4'b1000) begin n_bad++; $display("FAIL handoff_d: got %b want 1000", bus.oGNT); end
    n_cmp++; if (bus.oBUSY !== 1'b1) begin n_bad++; $display("FAIL handoff_nogap: got %b want 1", bus.oBUSY); end
    drive_step(1'b1, 4'b0000);
    n_cmp++; if (bus.oGNT !== 4'b0000) begin n_bad++; $display("FAIL handoff_idle: got %b want 0000", bus.oGNT); end
    n_cmp++; if (bus.oSEL !== 2'd3) begin n_bad++; $display("FAIL handoff_sel_hold: got %0d want 3", bus.oSEL); end
  endtask

  task automatic test_data();
    bus.iA = 8'h11; bus.iB = 8'h22; bus.iC = 8'h33; bus.iD = 8'h44;
    drive_step(1'b1, 4'b0100);
    n_cmp++; if (bus.oGNT !== 4'b0100) begin n_bad++; $display("FAIL data_gnt_c: got %b want 0100", bus.oGNT); end
    n_cmp++; if (bus.oVALID !== 1'b0) begin n_bad++; $display("FAIL data_valid_early: got %b want 0", bus.oVALID); end
    drive_step(1'b1, 4'b0100);
    n_cmp++; if (bus.oOUT !== 8'h33) begin n_bad++; $display("FAIL data_out_c: got %h want 33", bus.oOUT); end
    n_cmp++; if (bus.oVALID !== 1'b1) begin n_bad++; $display("FAIL data_valid: got %b want 1", bus.oVALID); end
    drive_step(1'b1, 4'b0000);
    drive_step(1'b1, 4'b0000);
    n_cmp++; if (bus.oVALID !== 1'b0) begin n_bad++; $display("FAIL data_valid_idle: got %b want 0", bus.oVALID); end
    n_cmp++; if (bus.oOUT !== 8'h33) begin n_bad++; $display("FAIL data_out_hold: got %h want 33", bus.oOUT); end
  endtask

  task automatic test_enable();
    drive_step(1'b1, 4'b0010);
    n_cmp++; if (bus.oGNT !== 4'b0010) begin n_bad++; $display("FAIL en_b_grant: got %b want 0010", bus.oGNT); end
    drive_step(1'b0, 4'b0011);
    n_cmp++; if (bus.oGNT !== 4'b0010) begin n_bad++; $display("FAIL en_b_kept: got %b want 0010", bus.oGNT); end
    drive_step(1'b0, 4'b0001);
    n_cmp++; if (bus.oGNT !== 4'b0000) begin n_bad++; $display("FAIL en_idle: got %b want 0000", bus.oGNT); end
    drive_step(1'b0, 4'b0001);
    n_cmp++; if (bus.oBUSY !== 1'b0) begin n_bad++; $display("FAIL en_blocked: got %b want 0", bus.oBUSY); end
    drive_step(1'b1, 4'b0001);
    n_cmp++; if (bus.oGNT !== 4'b0001) begin n_bad++; $display("FAIL en_a_grant: got %b want 0001", bus.oGNT); end
    drive_step(1'b1, 4'b0000);
  endtask

  task automatic test_hold();
    int exp_o;
    bit exp_p;
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      drive_step(1'b1, 4'b0011);
      exp_o = TO_EN ? (c / MH) % 2 : 0;
      exp_p = TO_EN && c > 0 && (c % MH) == 0;
      n_cmp++; if (bus.oGNT !== gnt_of(exp_o)) begin n_bad++; $display("FAIL hold_gnt c=%0d: got %b want %b", c, bus.oGNT, gnt_of(exp_o)); end
      n_cmp++; if (bus.oPREEMPT !== exp_p) begin n_bad++; $display("FAIL hold_preempt c=%0d: got %b want %b", c, bus.oPREEMPT, exp_p); end
    end
    drive_step(1'b1, 4'b0000);
  endtask

  task automatic test_async_reset();
    drive_step(1'b1, 4'b0100);
    drive_step(1'b1, 4'b0100);
    n_cmp++; if (bus.oVALID !== 1'b1) begin n_bad++; $display("FAIL arst_pre_valid: got %b want 1", bus.oVALID); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.oGNT !== 4'b0000) begin n_bad++; $display("FAIL arst_gnt: got %b want 0000", bus.oGNT); end
    n_cmp++; if (bus.oVALID !== 1'b0) begin n_bad++; $display("FAIL arst_valid: got %b want 0", bus.oVALID); end
    n_cmp++; if (bus.oBUSY !== 1'b0) begin n_bad++; $display("FAIL arst_busy: got %b want 0", bus.oBUSY); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive_step(1'b1, 4'hF);
    n_cmp++; if (bus.oGNT !== 4'b0001) begin n_bad++; $display("FAIL arst_ptr0: got %b want 0001", bus.oGNT); end
  endtask

  task automatic test_random();
    logic [3:0] req;
    bit en;
    req = 4'b0000;
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
      en = ($urandom_range(0, 3) != 0);
      bus.iA = 8'($urandom); bus.iB = 8'($urandom);
      bus.iC = 8'($urandom); bus.iD = 8'($urandom);
      drive_step(en, req);
      n_cmp++; if ({bus.oGNT, bus.oSEL} !== {gnt_of(m_owner), 2'(m_sel)}) begin n_bad++;
        $display("FAIL rnd_gnt_sel n=%0d: got %b/%0d want %b/%0d", n, bus.oGNT, bus.oSEL, gnt_of(m_owner), m_sel); end
      n_cmp++; if ({bus.oOUT, bus.oVALID} !== {m_out, m_valid}) begin n_bad++;
        $display("FAIL rnd_out_valid n=%0d: got %h/%b want %h/%b", n, bus.oOUT, bus.oVALID, m_out, m_valid); end
      n_cmp++; if ({bus.oBUSY, bus.oPREEMPT} !== {(m_owner >= 0), m_preempt}) begin n_bad++;
        $display("FAIL rnd_busy_preempt n=%0d: got %b%b want %b%b", n, bus.oBUSY, bus.oPREEMPT, (m_owner >= 0), m_preempt); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_handoff();
    test_data();
    test_enable();
    test_hold();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
